core_trap_ctrl: RTL and testbench

//   Trap/return sequencer sitting directly upstream of core_rtu's CSR write port. Takes exceptions

---
 rtl/core_trap_ctrl.sv | 159 +++++++++++++++
 tb/tb_core_trap_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/core_trap_ctrl.sv
// rtl/core_trap_ctrl.sv - trap/mret sequencer driving the single CSR write port and fetch redirect
module core_trap_ctrl #(
    parameter int                  DATA_W       = 32,
    parameter int                  CSR_W        = 12,
    parameter logic [CSR_W-1:0]    MSTATUS_ADDR = 12'h300,
    parameter logic [CSR_W-1:0]    MEPC_ADDR    = 12'h341,
    parameter logic [CSR_W-1:0]    MCAUSE_ADDR  = 12'h342,
    parameter logic [DATA_W-1:0]   IRQ_CAUSE    = 32'h8000_000B
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              exc_req_i,
    input  logic [DATA_W-1:0] exc_cause_i,
    input  logic [DATA_W-1:0] exc_pc_i,
    input  logic              irq_i,
    input  logic [DATA_W-1:0] int_pc_i,
    input  logic              int_pc_vld_i,
    input  logic              mret_i,
    input  logic [CSR_W-1:0]  ex_csr_waddr_i,
    input  logic              ex_csr_waddr_vld_i,
    input  logic [DATA_W-1:0] ex_csr_wdata_i,
    input  logic [DATA_W-1:0] csr_mtvec_i,
    input  logic [DATA_W-1:0] csr_mepc_i,
    input  logic [DATA_W-1:0] csr_mstatus_i,
    output logic [CSR_W-1:0]  csr_waddr_o,
    output logic              csr_waddr_vld_o,
    output logic [DATA_W-1:0] csr_wdata_o,
    output logic              stall_o,
    output logic              flush_o,
    output logic              jump_vld_o,
    output logic [DATA_W-1:0] jump_addr_o
);

    typedef enum logic [2:0] {
        IDLE,
        W_MEPC,
        W_MCAUSE,
        W_MSTATUS,
        R_MSTATUS,
        JUMP
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] pc_q;
    logic [DATA_W-1:0] cause_q;
    logic              mret_q;

    logic is_idle, take_exc, take_irq, take_mret, accept;
    logic [DATA_W-1:0] trap_mstatus, mret_mstatus;

    assign is_idle   = (state_q == IDLE);
    assign take_exc  = is_idle & exc_req_i;
    assign take_irq  = is_idle & ~exc_req_i & irq_i & csr_mstatus_i[3] & int_pc_vld_i;
    assign take_mret = is_idle & ~exc_req_i & ~(irq_i & csr_mstatus_i[3] & int_pc_vld_i) & mret_i;
    assign accept    = take_exc | take_irq | take_mret;

    // MPIE <- MIE, MIE <- 0 on trap; MIE <- MPIE, MPIE <- 1 on return; MPP stays machine mode.
    always_comb begin
        trap_mstatus        = csr_mstatus_i;
        trap_mstatus[7]     = csr_mstatus_i[3];
        trap_mstatus[3]     = 1'b0;
        trap_mstatus[12:11] = 2'b11;
        mret_mstatus        = csr_mstatus_i;
        mret_mstatus[3]     = csr_mstatus_i[7];
        mret_mstatus[7]     = 1'b1;
        mret_mstatus[12:11] = 2'b11;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            pc_q    <= '0;
            cause_q <= '0;
            mret_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (take_exc) begin
                pc_q    <= exc_pc_i;
                cause_q <= exc_cause_i;
                mret_q  <= 1'b0;
            end else if (take_irq) begin
                pc_q    <= int_pc_i;
                cause_q <= IRQ_CAUSE;
                mret_q  <= 1'b0;
            end else if (take_mret) begin
                mret_q  <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        csr_waddr_o     = '0;
        csr_waddr_vld_o = 1'b0;
        csr_wdata_o     = '0;
        stall_o         = 1'b1;
        flush_o         = 1'b0;
        jump_vld_o      = 1'b0;
        jump_addr_o     = '0;
        case (state_q)
            IDLE: begin
                if (take_exc || take_irq) begin
                    state_d = W_MEPC;
                end else if (take_mret) begin
                    state_d = R_MSTATUS;
                end else begin
                    stall_o         = 1'b0;
                    csr_waddr_o     = ex_csr_waddr_i;
                    csr_waddr_vld_o = ex_csr_waddr_vld_i;
                    csr_wdata_o     = ex_csr_wdata_i;
                end
            end
            W_MEPC: begin
                state_d         = W_MCAUSE;
                csr_waddr_o     = MEPC_ADDR;
                csr_waddr_vld_o = 1'b1;
                csr_wdata_o     = pc_q;
            end
            W_MCAUSE: begin
                state_d         = W_MSTATUS;
                csr_waddr_o     = MCAUSE_ADDR;
                csr_waddr_vld_o = 1'b1;
                csr_wdata_o     = cause_q;
            end
            W_MSTATUS: begin
                state_d         = JUMP;
                csr_waddr_o     = MSTATUS_ADDR;
                csr_waddr_vld_o = 1'b1;
                csr_wdata_o     = trap_mstatus;
            end
            R_MSTATUS: begin
                state_d         = JUMP;
                csr_waddr_o     = MSTATUS_ADDR;
                csr_waddr_vld_o = 1'b1;
                csr_wdata_o     = mret_mstatus;
            end
            JUMP: begin
                state_d     = IDLE;
                flush_o     = 1'b1;
                jump_vld_o  = 1'b1;
                jump_addr_o = mret_q ? csr_mepc_i : {csr_mtvec_i[DATA_W-1:2], 2'b00};
            end
            default: state_d = IDLE;
        endcase
        if (!rst_n_i) begin
            csr_waddr_o     = '0;
            csr_waddr_vld_o = 1'b0;
            csr_wdata_o     = '0;
            stall_o         = 1'b0;
            flush_o         = 1'b0;
            jump_vld_o      = 1'b0;
            jump_addr_o     = '0;
        end
    end

    logic unused_ok;
    assign unused_ok = accept;

endmodule

// File: tb/tb_core_trap_ctrl.sv
// tb/tb_core_trap_ctrl.sv - self-checking bench for core_trap_ctrl against a sequence-level model
module tb_core_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        exc_req, irq, int_pc_vld, mret, ex_vld;
    logic [31:0] exc_cause, exc_pc, int_pc, ex_wdata, mtvec, mepc, mstatus;
    logic [11:0] ex_waddr;
    logic [11:0] csr_waddr;
    logic        csr_vld, stall, flush, jump_vld;
    logic [31:0] csr_wdata, jump_addr;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic        vld;
        logic [11:0] addr;
        logic [31:0] data;
        logic        jump;
        logic [31:0] jaddr;
    } exp_t;

    always #5 clk = ~clk;

    core_trap_ctrl dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .exc_req_i(exc_req), .exc_cause_i(exc_cause), .exc_pc_i(exc_pc),
        .irq_i(irq), .int_pc_i(int_pc), .int_pc_vld_i(int_pc_vld), .mret_i(mret),
        .ex_csr_waddr_i(ex_waddr), .ex_csr_waddr_vld_i(ex_vld), .ex_csr_wdata_i(ex_wdata),
        .csr_mtvec_i(mtvec), .csr_mepc_i(mepc), .csr_mstatus_i(mstatus),
        .csr_waddr_o(csr_waddr), .csr_waddr_vld_o(csr_vld), .csr_wdata_o(csr_wdata),
        .stall_o(stall), .flush_o(flush), .jump_vld_o(jump_vld), .jump_addr_o(jump_addr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_ex();
        ex_vld   = 1'($urandom_range(0, 1));
        ex_waddr = 12'($urandom);
        ex_wdata = $urandom;
    endtask

    task automatic idle_check(input string tag);
        exc_req    = 1'b0;
        mret       = 1'b0;
        irq        = 1'($urandom_range(0, 1));
        int_pc_vld = 1'($urandom_range(0, 1));
        if (irq && int_pc_vld) mstatus[3] = 1'b0;
        rand_ex();
        #3;
        check({tag, ".stall"}, {31'b0, stall}, 32'd0);
        check({tag, ".vld"},   {31'b0, csr_vld}, {31'b0, ex_vld});
        check({tag, ".addr"},  {20'b0, csr_waddr}, {20'b0, ex_waddr});
        check({tag, ".data"},  csr_wdata, ex_wdata);
        check({tag, ".jump"},  {30'b0, jump_vld, flush}, 32'd0);
        tick();
    endtask

    // kind: 0 = exception, 1 = interrupt (pc is int_pc), 2 = mret
    task automatic run_seq(input int kind, input logic [31:0] pc, input logic [31:0] cause,
                           input logic [31:0] tvec, input logic [31:0] ms, input logic [31:0] epc,
                           input logic [11:0] ex_a, input logic [31:0] ex_d, input string tag);
        exp_t        q[$];
        exp_t        e;
        logic [31:0] ms_t, ms_m, exp_cause;
        if (kind == 1) ms = ms | 32'h8;
        ms_t      = (ms & ~32'h1888) | ({31'b0, ms[3]} << 7) | 32'h1800;
        ms_m      = (ms & ~32'h1888) | ({31'b0, ms[7]} << 3) | 32'h1880;
        exp_cause = (kind == 1) ? 32'h8000_000B : cause;
        mtvec = tvec; mepc = epc; mstatus = ms;
        ex_vld = 1'b1; ex_waddr = ex_a; ex_wdata = ex_d;
        exc_cause = cause; exc_pc = $urandom; int_pc = $urandom;
        case (kind)
            0: begin
                exc_req = 1'b1; exc_pc = pc;
                irq = 1'($urandom_range(0, 1)); int_pc_vld = 1'($urandom_range(0, 1));
                mret = 1'($urandom_range(0, 1));
            end
            1: begin
                exc_req = 1'b0; irq = 1'b1; int_pc_vld = 1'b1; int_pc = pc;
                mret = 1'($urandom_range(0, 1));
            end
            default: begin
                exc_req = 1'b0; irq = 1'($urandom_range(0, 1)); int_pc_vld = 1'b0; mret = 1'b1;
            end
        endcase
        #3;
        check({tag, ".acc_stall"}, {31'b0, stall}, 32'd1);
        check({tag, ".acc_vld"},   {31'b0, csr_vld}, 32'd0);
        check({tag, ".acc_jump"},  {30'b0, jump_vld, flush}, 32'd0);
        tick();
        if (kind == 2) begin
            e = '{1'b1, 12'h300, ms_m, 1'b0, 32'd0};        q.push_back(e);
            e = '{1'b0, 12'h000, 32'd0, 1'b1, epc};         q.push_back(e);
        end else begin
            e = '{1'b1, 12'h341, pc, 1'b0, 32'd0};          q.push_back(e);
            e = '{1'b1, 12'h342, exp_cause, 1'b0, 32'd0};   q.push_back(e);
            e = '{1'b1, 12'h300, ms_t, 1'b0, 32'd0};        q.push_back(e);
            e = '{1'b0, 12'h000, 32'd0, 1'b1, tvec & ~32'h3}; q.push_back(e);
        end
        foreach (q[i]) begin
            exc_req = 1'($urandom_range(0, 1)); mret = 1'($urandom_range(0, 1));
            irq = 1'($urandom_range(0, 1)); int_pc_vld = 1'($urandom_range(0, 1));
            exc_pc = $urandom; exc_cause = $urandom; int_pc = $urandom;
            rand_ex();
            #3;
            check($sformatf("%s.c%0d_stall", tag, i + 1), {31'b0, stall}, 32'd1);
            check($sformatf("%s.c%0d_vld", tag, i + 1), {31'b0, csr_vld}, {31'b0, q[i].vld});
            if (q[i].vld) begin
                check($sformatf("%s.c%0d_addr", tag, i + 1), {20'b0, csr_waddr}, {20'b0, q[i].addr});
                check($sformatf("%s.c%0d_data", tag, i + 1), csr_wdata, q[i].data);
            end
            check($sformatf("%s.c%0d_jump", tag, i + 1), {30'b0, jump_vld, flush},
                  q[i].jump ? 32'd3 : 32'd0);
            if (q[i].jump) check($sformatf("%s.c%0d_jaddr", tag, i + 1), jump_addr, q[i].jaddr);
            tick();
        end
        idle_check({tag, ".after"});
    endtask

    initial begin
        rst_n = 1'b0;
        exc_req = 0; irq = 0; int_pc_vld = 0; mret = 0; ex_vld = 0;
        exc_cause = 0; exc_pc = 0; int_pc = 0; ex_wdata = 0; ex_waddr = 0;
        mtvec = 0; mepc = 0; mstatus = 0;
        tick(); tick();
        #3;
        check("reset.ctl", {28'b0, csr_vld, stall, flush, jump_vld}, 32'd0);
        check("reset.addr", {20'b0, csr_waddr}, 32'd0);
        check("reset.data", csr_wdata, 32'd0);
        check("reset.jaddr", jump_addr, 32'd0);
        tick();
        rst_n = 1'b1;

        run_seq(0, 32'h100, 32'd2, 32'h2001, 32'h8, 32'h0, 12'h123, 32'h1, "t1_exc");
        run_seq(2, 32'h0, 32'h0, 32'h2001, 32'h1880, 32'h104, 12'h123, 32'h1, "t2_mret");

        mstatus = 32'h0; exc_req = 0; mret = 0; irq = 1; int_pc_vld = 1; int_pc = 32'h200;
        ex_vld = 0; ex_waddr = 0; ex_wdata = 0;
        for (int i = 0; i < 3; i++) begin
            #3;
            check($sformatf("t3_mie0.stall%0d", i), {31'b0, stall}, 32'd0);
            tick();
            check($sformatf("t3_mie0.idle%0d", i), {31'b0, stall, csr_vld}, 32'd0);
        end
        mstatus = 32'h0; irq = 1; int_pc_vld = 0;
        #3;
        check("t3_pcinv.stall", {31'b0, stall}, 32'd0);
        tick();
        run_seq(1, 32'h200, 32'h0, 32'h4000, 32'h8, 32'h0, 12'h123, 32'h1, "t3_irq");

        run_seq(0, 32'h180, 32'd5, 32'h3000, 32'h0, 32'h0, 12'h340, 32'h55, "t4_exwr");

        exc_req = 1; exc_pc = 32'h500; exc_cause = 32'd7; irq = 0; mret = 0;
        ex_vld = 0; ex_waddr = 0; ex_wdata = 0; mstatus = 32'h8; mtvec = 32'h2000;
        #3; tick();
        exc_req = 0; #3;
        check("t5.mepc_addr", {20'b0, csr_waddr}, 32'h341);
        tick();
        rst_n = 1'b0; #3; tick();
        #3;
        check("t5.rst_ctl", {28'b0, csr_vld, stall, flush, jump_vld}, 32'd0);
        check("t5.rst_data", csr_wdata, 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #3;
            check($sformatf("t5.post%0d", i), {28'b0, csr_vld, stall, flush, jump_vld}, 32'd0);
            tick();
        end

        exc_req = 0; irq = 0; mret = 0; ex_vld = 1; ex_waddr = 12'h305; ex_wdata = 32'h3000;
        #3;
        check("t6.addr", {20'b0, csr_waddr}, 32'h305);
        check("t6.vld", {31'b0, csr_vld}, 32'd1);
        check("t6.data", csr_wdata, 32'h3000);
        check("t6.stall", {31'b0, stall}, 32'd0);
        tick();

        for (int n = 0; n < 40; n++) begin
            run_seq(int'($urandom_range(0, 2)), $urandom, $urandom, $urandom, $urandom, $urandom,
                    12'($urandom), $urandom, $sformatf("rnd%0d", n));
            if ($urandom_range(0, 1) == 1) idle_check($sformatf("rnd%0d.idle", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
